// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg
// Shared constants for the ALU result display slice.
//   - SEG_BLANK / SEG_MINUS : whole-digit patterns (active-low, bit order g..a)
//   - GLYPH_0 .. GLYPH_F    : hex font, active-low, seg[0]=a .. seg[6]=g
package alu_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;  // only segment g lit

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/alu_result_disp_font.sv
// hex7seg_font
// Purely combinational hex-to-seven-segment font.
//   nibble : 4-bit value to render (0-F)
//   glyph  : active-low segments, glyph[0]=a .. glyph[6]=g
module hex7seg_font
  import alu_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_disp.sv
// alu_result_disp
// Captures 4-bit signed ALU results over a valid/ready handshake, holds each
// one for at least HOLD_CYC cycles, and shows it on a 2-digit multiplexed
// active-low seven-segment display.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   in_valid : upstream result available on in_data
//   in_ready : result accepted on an edge where in_valid is also high
//   in_data  : two's-complement result, -8..7
//   hex_mode : 0 = signed decimal, 1 = raw hex nibble
//   seg      : active-low segments, seg[0]=a .. seg[6]=g
//   an       : active-low digit enables, an[0]=magnitude, an[1]=sign
//   busy     : hold counter nonzero (always ~in_ready)
module alu_result_disp
  import alu_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int HOLD_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       hex_mode,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy
);

  // HOLD_CYC=1 needs no counting at all, but still a 1-bit register that
  // simply never leaves zero.
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    hold_reg;
  logic          have;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] scan_cnt;
  logic          dig;
  logic          xfer;

  assign in_ready = (hold_cnt == '0);
  assign busy     = ~in_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= 4'h0;
      have     <= 1'b0;
      hold_cnt <= '0;
    end else if (xfer) begin
      hold_reg <= in_data;
      have     <= 1'b1;
      hold_cnt <= HOLD_LOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Digit scan is free-running and unrelated to the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig      <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig      <= ~dig;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Magnitude at 5 bits so that -8 yields +8 rather than wrapping back to -8.
  logic [4:0] sext;
  logic [4:0] mag_wide;
  logic       mag_unused;
  logic [3:0] font_in;
  logic [6:0] glyph;

  assign sext       = {hold_reg[3], hold_reg};
  assign mag_wide   = hold_reg[3] ? (5'd0 - sext) : sext;
  // Bit 4 is always zero for inputs in -8..7; only the low nibble is drawn.
  assign mag_unused = mag_wide[4];
  assign font_in    = hex_mode ? hold_reg : mag_wide[3:0];

  hex7seg_font u_font (
    .nibble (font_in),
    .glyph  (glyph)
  );

  // Display depends only on registered state plus hex_mode; in_data never
  // reaches seg combinationally.
  always_comb begin
    seg = SEG_BLANK;
    if (have) begin
      if (!dig) begin
        seg = glyph;
      end else if (!hex_mode && hold_reg[3]) begin
        seg = SEG_MINUS;
      end
    end
  end

  assign an = dig ? 2'b01 : 2'b10;

endmodule

// File: tb/tb_alu_result_disp.sv
module tb_alu_result_disp;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       hex_mode;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_result_disp #(.SCAN_DIV(4), .HOLD_CYC(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .hex_mode (hex_mode),
    .seg      (seg),
    .an       (an),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-12s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present d until accepted; returns the edge index of the transfer.
  // keep=1 leaves in_valid asserted afterwards (continuous upstream).
  task automatic send(input logic [3:0] d, input bit keep, output int edge_idx);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: observed=in_ready low required=in_ready high");
    end
    @(posedge clk);
    #1;
    edge_idx = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait (bounded) for digit `which` to be enabled, then check its segments.
  task automatic show(input logic [1:0] which, input string tag, input logic [6:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (an !== which && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_an"}, {6'd0, an}, {6'd0, which});
    check(tag, {1'b0, seg}, {1'b0, exp});
  endtask

  initial begin
    int e, k1, k2, k3, c;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    hex_mode = 1'b0;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", {7'd0, in_ready}, 8'd1);
    check("rst_busy",  {7'd0, busy},     8'd0);
    check("rst_an",    {6'd0, an},       8'h02);
    check("rst_seg",   {1'b0, seg},      8'h7F);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Digit toggles on every 4th edge after release; display stays blank.
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("scan_an%0d", n), {6'd0, an}, (((n / 4) % 2) == 1) ? 8'h01 : 8'h02);
      check($sformatf("scan_seg%0d", n), {1'b0, seg}, 8'h7F);
    end

    // +3 decimal
    send(4'b0011, 1'b0, e);
    @(negedge clk);
    check("vis_3", {1'b0, seg}, (an == 2'b10) ? 8'h30 : 8'h7F);
    show(2'b10, "d0_p3", 7'h30);
    show(2'b01, "d1_p3", 7'h7F);

    // -3 decimal
    send(4'b1101, 1'b0, e);
    show(2'b10, "d0_m3", 7'h30);
    show(2'b01, "d1_m3", 7'h3F);

    // -8 decimal: magnitude 8, not wrapped
    send(4'b1000, 1'b0, e);
    show(2'b10, "d0_m8", 7'h00);
    show(2'b01, "d1_m8", 7'h3F);

    // 1010 decimal (-6), then hex_mode flipped mid-cycle
    send(4'b1010, 1'b0, e);
    show(2'b01, "d1_m6", 7'h3F);
    show(2'b10, "d0_m6", 7'h02);
    hex_mode = 1'b1;
    #1;
    check("hex_now", {1'b0, seg}, 8'h08);
    show(2'b10, "d0_hexA", 7'h08);
    show(2'b01, "d1_hexA", 7'h7F);
    hex_mode = 1'b0;

    // Continuous valid: transfers spaced exactly HOLD_CYC edges apart
    send(4'd1, 1'b1, k1);
    check("hold_busy",  {7'd0, busy},     8'd1);
    check("hold_rdy0",  {7'd0, in_ready}, 8'd0);
    check("hold_v1",    {1'b0, seg}, (an == 2'b10) ? 8'h79 : 8'h7F);
    send(4'd2, 1'b1, k2);
    check("hold_v2",    {1'b0, seg}, (an == 2'b10) ? 8'h24 : 8'h7F);
    send(4'd3, 1'b0, k3);
    check("hold_v3",    {1'b0, seg}, (an == 2'b10) ? 8'h30 : 8'h7F);
    check("hold_gap1",  8'(k2 - k1), 8'd8);
    check("hold_gap2",  8'(k3 - k2), 8'd8);
    show(2'b10, "d0_last3", 7'h30);

    // Reset 3 cycles into a hold aborts it immediately
    send(4'd5, 1'b0, e);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ready", {7'd0, in_ready}, 8'd1);
    check("mrst_busy",  {7'd0, busy},     8'd0);
    check("mrst_seg",   {1'b0, seg},      8'h7F);
    check("mrst_an",    {6'd0, an},       8'h02);
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    send(4'd7, 1'b0, e);
    check("mrst_first", 8'(e - c), 8'd1);
    check("mrst_d0",    {1'b0, seg},      8'h78);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
